// File: rtl/zerosoc_pad_pkg.sv
// Shared pad-ring constants for zerosoc: GPIO bus width, input conditioning
// defaults, per-side GPIO slices and west-side control pad placement.
package zerosoc_pad_pkg;

  localparam int GpioWidth     = 32;
  localparam int DefSyncStages = 2;
  localparam int DefFilterCnt  = 4;

  // GPIO bits assigned to each side of the pad ring (inclusive ranges).
  localparam int WestGpioLo  = 0;
  localparam int WestGpioHi  = 4;
  localparam int NorthGpioLo = 5;
  localparam int NorthGpioHi = 13;
  localparam int EastGpioLo  = 14;
  localparam int EastGpioHi  = 22;
  localparam int SouthGpioLo = 23;
  localparam int SouthGpioHi = 31;

  // West-side control pad indices.
  localparam int WestPadClk    = 5;
  localparam int WestPadRst    = 6;
  localparam int WestPadUartRx = 7;
  localparam int WestPadUartTx = 8;

  typedef enum logic [1:0] {
    SIDE_WEST  = 2'd0,
    SIDE_NORTH = 2'd1,
    SIDE_EAST  = 2'd2,
    SIDE_SOUTH = 2'd3
  } pad_side_e;

  // Per-bit filter action taken on a clock edge; visible on the debug port.
  typedef enum logic [1:0] {
    FILT_IDLE   = 2'd0,  // synchronized level matches output, counter clears
    FILT_COUNT  = 2'd1,  // new level pending, counter advances
    FILT_ACCEPT = 2'd2,  // new level held long enough, output updates
    FILT_BYPASS = 2'd3   // filter disabled, output follows synchronizer
  } filt_act_e;

  // Which side of the ring carries a given GPIO bit.
  function automatic pad_side_e gpio_side(input int idx);
    if (idx <= WestGpioHi)       return SIDE_WEST;
    else if (idx <= NorthGpioHi) return SIDE_NORTH;
    else if (idx <= EastGpioHi)  return SIDE_EAST;
    else                         return SIDE_SOUTH;
  endfunction

endpackage

// File: rtl/gpio_in_filter_bit.sv
// Single-bit input conditioner: synchronizer chain, glitch filter with
// bypass, registered output level and registered rise/fall event pulses.
module gpio_in_filter_bit
  import zerosoc_pad_pkg::*;
#(
  parameter int SyncStages = DefSyncStages,
  parameter int FilterCnt  = DefFilterCnt
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      pad_i,
  input  logic      filter_en_i,
  output logic      level_o,
  output logic      rise_o,
  output logic      fall_o,
  output filt_act_e act_o
);

  localparam int CntW = $clog2(FilterCnt + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FilterCnt - 1);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  level_q, level_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  sync_lvl;
  filt_act_e             act;

  assign sync_lvl = sync_q[SyncStages-1];

  // Next-state: shift synchronizer, decide filter action, derive edge pulses
  // from the level about to be registered so they line up with the change.
  always_comb begin
    sync_d  = {sync_q[SyncStages-2:0], pad_i};
    cnt_d   = '0;
    level_d = level_q;
    act     = FILT_IDLE;
    if (!filter_en_i) begin
      act     = FILT_BYPASS;
      level_d = sync_lvl;
    end else if (sync_lvl == level_q) begin
      act = FILT_IDLE;
    end else if (cnt_q == CntLast) begin
      act     = FILT_ACCEPT;
      level_d = sync_lvl;
    end else begin
      act   = FILT_COUNT;
      cnt_d = cnt_q + CntW'(1);
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign act_o   = act;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Conditions Width asynchronous pad inputs into the clk_i domain: per-bit
// synchronizer, programmable glitch filter and rise/fall event pulses.
// There is no handshake: gpio_o is a level, and rise_o/fall_o are one-cycle
// pulses valid in the cycle they are high, with no backpressure.
module gpio_in_conditioner
  import zerosoc_pad_pkg::*;
#(
  parameter int Width      = GpioWidth,
  parameter int SyncStages = DefSyncStages,
  parameter int FilterCnt  = DefFilterCnt
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] pad_din_i,
  input  logic [Width-1:0] filter_en_i,
  output logic [Width-1:0] gpio_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  output filt_act_e        dbg_act_o [Width]
);

  // One independent conditioner per pad bit.
  for (genvar i = 0; i < Width; i++) begin : g_bit
    gpio_in_filter_bit #(
      .SyncStages (SyncStages),
      .FilterCnt  (FilterCnt)
    ) u_bit (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .pad_i       (pad_din_i[i]),
      .filter_en_i (filter_en_i[i]),
      .level_o     (gpio_o[i]),
      .rise_o      (rise_o[i]),
      .fall_o      (fall_o[i]),
      .act_o       (dbg_act_o[i])
    );
  end

endmodule
